// File: rtl/pc_seq_pkg.sv
// Shared types and sizing helpers for the program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;
    typedef enum logic [1:0] {F_NONE, F_OVF, F_UNF} fault_t;

    // Bits needed to count 0..entries inclusive.
    function automatic int depth_w(input int entries);
        return (entries < 1) ? 1 : $clog2(entries + 1);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/status bundle between the control FSM (master) and the sequencer (slave).
import pc_seq_pkg::*;

interface pc_seq_if #(
    parameter int ADDR_W      = 7,
    parameter int OFF_W       = 5,
    parameter int STACK_DEPTH = 4
);
    localparam int DW = depth_w(STACK_DEPTH);

    logic              up;
    logic              load;
    logic [ADDR_W-1:0] load_addr;
    logic              jump_rel;
    logic [OFF_W-1:0]  offset;
    logic              call;
    logic              ret;
    logic              halt;
    logic              resume;

    logic [ADDR_W-1:0] address;
    logic [DW-1:0]     depth;
    logic              stack_full;
    logic              stack_empty;
    logic              at_max;
    logic              halted;
    logic              fault;
    logic [1:0]        fault_code;

    modport master (
        output up, load, load_addr, jump_rel, offset, call, ret, halt, resume,
        input  address, depth, stack_full, stack_empty, at_max, halted, fault, fault_code
    );

    modport slave (
        input  up, load, load_addr, jump_rel, offset, call, ret, halt, resume,
        output address, depth, stack_full, stack_empty, at_max, halted, fault, fault_code
    );
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Return-address LIFO; push/pop are ignored when full/empty, the caller flags the error.
import pc_seq_pkg::*;

module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 7,
    localparam int DW   = depth_w(DEPTH),
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  top,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign full   = (depth == DW'(DEPTH));
    assign empty  = (depth == '0);
    assign wr_idx = AW'(depth);
    assign rd_idx = AW'(depth - DW'(1));
    assign top    = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (clear)
            depth <= '0;
        else if (push && !full)
            depth <= depth + DW'(1);
        else if (pop && !empty)
            depth <= depth - DW'(1);
    end

    // Contents are left stale on clear; depth alone defines validity.
    always_ff @(posedge clk) begin
        if (!clear && push && !full)
            mem[wr_idx] <= din;
    end
endmodule

// File: rtl/pc_sequencer.sv
// PC register with load / relative jump / call-return, plus RUN/HALTED/FAULT control.
import pc_seq_pkg::*;

module pc_sequencer #(
    parameter int ADDR_W      = 7,
    parameter int OFF_W       = 5,
    parameter int STACK_DEPTH = 4,
    parameter bit WRAP        = 1'b1
) (
    input  logic    clk,
    input  logic    clear,
    pc_seq_if.slave bus
);
    localparam int DW = depth_w(STACK_DEPTH);

    state_t            state, nxt_state;
    fault_t            fcode, nxt_fcode;
    logic [ADDR_W-1:0] pc, nxt_pc;
    logic              push, pop;
    logic [ADDR_W-1:0] ras_top;
    logic [DW-1:0]     ras_depth;
    logic              ras_full, ras_empty;
    logic              pc_max;

    assign pc_max = (pc == '1);

    ras_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_ras (
        .clk   (clk),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (pc + ADDR_W'(1)),
        .top   (ras_top),
        .depth (ras_depth),
        .full  (ras_full),
        .empty (ras_empty)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= RUN;
            fcode <= F_NONE;
            pc    <= '0;
        end else begin
            state <= nxt_state;
            fcode <= nxt_fcode;
            pc    <= nxt_pc;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_fcode = fcode;
        nxt_pc    = pc;
        push      = 1'b0;
        pop       = 1'b0;
        unique case (state)
            RUN: begin
                if (bus.halt) begin
                    nxt_state = HALTED;
                end else if (bus.ret) begin
                    if (ras_empty) begin
                        nxt_state = FAULT;
                        nxt_fcode = F_UNF;
                    end else begin
                        pop    = 1'b1;
                        nxt_pc = ras_top;
                    end
                end else if (bus.call) begin
                    if (ras_full) begin
                        nxt_state = FAULT;
                        nxt_fcode = F_OVF;
                    end else begin
                        push   = 1'b1;
                        nxt_pc = bus.load_addr;
                    end
                end else if (bus.load) begin
                    nxt_pc = bus.load_addr;
                end else if (bus.jump_rel) begin
                    // Relative jumps always wrap modulo 2^ADDR_W.
                    nxt_pc = pc + ADDR_W'($signed(bus.offset));
                end else if (bus.up) begin
                    if (!(pc_max && !WRAP))
                        nxt_pc = pc + ADDR_W'(1);
                end
            end
            HALTED: begin
                if (bus.resume)
                    nxt_state = RUN;
            end
            FAULT: ;
            default: nxt_state = RUN;
        endcase
    end

    assign bus.address     = pc;
    assign bus.depth       = ras_depth;
    assign bus.stack_full  = ras_full;
    assign bus.stack_empty = ras_empty;
    assign bus.at_max      = pc_max;
    assign bus.halted      = (state == HALTED);
    assign bus.fault       = (state == FAULT);
    assign bus.fault_code  = fcode;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: WRAP=1 and WRAP=0 sequencers driven with identical stimulus.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic clear = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pc_seq_if #(.ADDR_W(7), .OFF_W(5), .STACK_DEPTH(4)) b1 ();
    pc_seq_if #(.ADDR_W(7), .OFF_W(5), .STACK_DEPTH(4)) b0 ();

    assign b0.up        = b1.up;
    assign b0.load      = b1.load;
    assign b0.load_addr = b1.load_addr;
    assign b0.jump_rel  = b1.jump_rel;
    assign b0.offset    = b1.offset;
    assign b0.call      = b1.call;
    assign b0.ret       = b1.ret;
    assign b0.halt      = b1.halt;
    assign b0.resume    = b1.resume;

    pc_sequencer #(.ADDR_W(7), .OFF_W(5), .STACK_DEPTH(4), .WRAP(1'b1)) dut_w1 (
        .clk(clk), .clear(clear), .bus(b1.slave));
    pc_sequencer #(.ADDR_W(7), .OFF_W(5), .STACK_DEPTH(4), .WRAP(1'b0)) dut_w0 (
        .clk(clk), .clear(clear), .bus(b0.slave));

    typedef struct {
        logic       up, load, jmp, call, ret;
        logic [6:0] la;
        logic [4:0] off;
        int         a1, a0, depth, atmax1;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic u, ld, j, c, r, h, rs,
                         input logic [6:0] la, input logic [4:0] off);
        b1.up = u; b1.load = ld; b1.jump_rel = j; b1.call = c; b1.ret = r;
        b1.halt = h; b1.resume = rs; b1.load_addr = la; b1.offset = off;
        @(posedge clk);
        #1;
        b1.up = 0; b1.load = 0; b1.jump_rel = 0; b1.call = 0; b1.ret = 0;
        b1.halt = 0; b1.resume = 0; b1.load_addr = '0; b1.offset = '0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic four_calls();
        drive(0,0,0,1,0,0,0, 7'd10, 5'd0);
        drive(0,0,0,1,0,0,0, 7'd20, 5'd0);
        drive(0,0,0,1,0,0,0, 7'd30, 5'd0);
        drive(0,0,0,1,0,0,0, 7'd40, 5'd0);
    endtask

    initial begin
        //                up ld jmp call ret  la      off        a1   a0  dep atmax1
        vecs[0]  = '{0, 1, 0, 0, 0, 7'd126, 5'd0,     126, 126, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 0, 7'd0,   5'd0,     127, 127, 0, 1};
        vecs[2]  = '{1, 0, 0, 0, 0, 7'd0,   5'd0,     0,   127, 0, 0};
        vecs[3]  = '{1, 0, 0, 0, 0, 7'd0,   5'd0,     1,   127, 0, 0};
        vecs[4]  = '{0, 1, 0, 0, 0, 7'd10,  5'd0,     10,  10,  0, 0};
        vecs[5]  = '{0, 0, 1, 0, 0, 7'd0,   5'b11101, 7,   7,   0, 0};
        vecs[6]  = '{0, 0, 1, 0, 0, 7'd0,   5'd15,    22,  22,  0, 0};
        vecs[7]  = '{0, 1, 0, 0, 0, 7'd125, 5'd0,     125, 125, 0, 0};
        vecs[8]  = '{0, 0, 1, 0, 0, 7'd0,   5'd5,     2,   2,   0, 0};
        vecs[9]  = '{0, 1, 0, 0, 0, 7'd20,  5'd0,     20,  20,  0, 0};
        vecs[10] = '{0, 0, 0, 1, 0, 7'd50,  5'd0,     50,  50,  1, 0};
        vecs[11] = '{0, 0, 0, 0, 1, 7'd0,   5'd0,     21,  21,  0, 0};
        vecs[12] = '{1, 1, 0, 0, 0, 7'd40,  5'd0,     40,  40,  0, 0};
        vecs[13] = '{0, 1, 0, 1, 0, 7'd60,  5'd0,     60,  60,  1, 0};
        vecs[14] = '{1, 0, 1, 0, 0, 7'd0,   5'd1,     61,  61,  1, 0};
        vecs[15] = '{0, 0, 0, 0, 1, 7'd0,   5'd0,     41,  41,  0, 0};

        drive(0,0,0,0,0,0,0, 7'd0, 5'd0);
        do_clear();
        check("rst_addr",   int'(b1.address), 0);
        check("rst_depth",  int'(b1.depth), 0);
        check("rst_empty",  int'(b1.stack_empty), 1);
        check("rst_full",   int'(b1.stack_full), 0);
        check("rst_atmax",  int'(b1.at_max), 0);
        check("rst_halted", int'(b1.halted), 0);
        check("rst_fault",  int'(b1.fault), 0);
        check("rst_fcode",  int'(b1.fault_code), 0);

        for (int k = 1; k <= 130; k++) begin
            drive(1,0,0,0,0,0,0, 7'd0, 5'd0);
            check($sformatf("up_wrap[%0d]", k), int'(b1.address), k % 128);
            check($sformatf("up_sat[%0d]", k), int'(b0.address), (k > 127) ? 127 : k);
            check($sformatf("atmax_wrap[%0d]", k), int'(b1.at_max), (k % 128 == 127) ? 1 : 0);
        end

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].up, vecs[i].load, vecs[i].jmp, vecs[i].call, vecs[i].ret, 1'b0, 1'b0,
                  vecs[i].la, vecs[i].off);
            check($sformatf("vec%0d_addr_w1", i), int'(b1.address), vecs[i].a1);
            check($sformatf("vec%0d_addr_w0", i), int'(b0.address), vecs[i].a0);
            check($sformatf("vec%0d_depth", i), int'(b1.depth), vecs[i].depth);
            check($sformatf("vec%0d_empty", i), int'(b1.stack_empty), (vecs[i].depth == 0) ? 1 : 0);
            check($sformatf("vec%0d_atmax_w1", i), int'(b1.at_max), vecs[i].atmax1);
            check($sformatf("vec%0d_atmax_w0", i), int'(b0.at_max), (vecs[i].a0 == 127) ? 1 : 0);
            check($sformatf("vec%0d_fault", i), int'(b1.fault), 0);
        end

        // LIFO order, then underflow.
        do_clear();
        four_calls();
        check("fill_depth", int'(b1.depth), 4);
        check("fill_full",  int'(b1.stack_full), 1);
        drive(0,0,0,0,1,0,0, 7'd0, 5'd0); check("pop1", int'(b1.address), 31);
        drive(0,0,0,0,1,0,0, 7'd0, 5'd0); check("pop2", int'(b1.address), 21);
        drive(0,0,0,0,1,0,0, 7'd0, 5'd0); check("pop3", int'(b1.address), 11);
        drive(0,0,0,0,1,0,0, 7'd0, 5'd0); check("pop4", int'(b1.address), 1);
        drive(0,0,0,0,1,0,0, 7'd0, 5'd0);
        check("unf_fault", int'(b1.fault), 1);
        check("unf_code",  int'(b1.fault_code), 2);
        check("unf_addr",  int'(b1.address), 1);

        // Overflow: fifth call faults, resume and up ignored, clear recovers.
        do_clear();
        four_calls();
        drive(0,0,0,1,0,0,0, 7'd50, 5'd0);
        check("ovf_fault", int'(b1.fault), 1);
        check("ovf_code",  int'(b1.fault_code), 1);
        check("ovf_depth", int'(b1.depth), 4);
        check("ovf_addr",  int'(b1.address), 40);
        drive(1,0,0,0,0,0,1, 7'd0, 5'd0);
        check("ovf_resume_fault", int'(b1.fault), 1);
        check("ovf_resume_addr",  int'(b1.address), 40);
        clear = 1'b1;
        drive(1,1,0,0,0,0,0, 7'd99, 5'd0);
        clear = 1'b0;
        check("clr_addr",  int'(b1.address), 0);
        check("clr_fault", int'(b1.fault), 0);
        check("clr_code",  int'(b1.fault_code), 0);
        check("clr_depth", int'(b1.depth), 0);

        // Halt priority, ignored inputs while halted, resume priority.
        drive(0,1,0,0,0,0,0, 7'd5, 5'd0);
        drive(1,0,0,0,0,1,0, 7'd0, 5'd0);
        check("halt_halted", int'(b1.halted), 1);
        check("halt_addr",   int'(b1.address), 5);
        drive(1,1,0,1,0,0,0, 7'd70, 5'd0);
        check("halted_up_addr",  int'(b1.address), 5);
        check("halted_up_depth", int'(b1.depth), 0);
        drive(1,0,0,0,0,0,1, 7'd0, 5'd0);
        check("resume_halted", int'(b1.halted), 0);
        check("resume_addr",   int'(b1.address), 5);
        drive(1,0,0,0,0,0,0, 7'd0, 5'd0);
        check("resume_up", int'(b1.address), 6);
        drive(0,0,0,0,0,1,0, 7'd0, 5'd0);
        drive(0,0,0,0,0,1,1, 7'd0, 5'd0);
        check("halt_resume_run", int'(b1.halted), 0);
        drive(1,0,0,0,0,0,0, 7'd0, 5'd0);
        check("halt_resume_up", int'(b1.address), 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer that supersedes the fixed 7-bit up-counter. Feeds the instruction-memory address port.
- Adds absolute load, signed relative jump, and call/return through an internal return-address stack.
- Adds a halt state and a sticky fault state.
- Selectable wrap or saturate behaviour on increment.
- Sits between the control FSM and instruction ROM.

Parameters:
- ADDR_W, 7, address width in bits.
- OFF_W, 5, width of the signed relative-jump offset.
- STACK_DEPTH, 4, return-address stack entries (≥1).
- WRAP, 1, 1 = increment wraps max→0; 0 = increment saturates at max.

Ports:
- clk  in  1  rising-edge clock.
- clear  in  1  synchronous active-high reset.
- up  in  1  increment request.
- load  in  1  absolute load request.
- load_addr  in  ADDR_W  target for load and call.
- jump_rel  in  1  relative jump request.
- offset  in  OFF_W  signed two's-complement jump offset.
- call  in  1  push return address, jump to load_addr.
- ret  in  1  pop return address into the counter.
- halt  in  1  enter HALTED.
- resume  in  1  leave HALTED.
- address  out  ADDR_W  current PC.
- depth  out  $clog2(STACK_DEPTH+1)  stack occupancy.
- stack_full  out  1  depth==STACK_DEPTH.
- stack_empty  out  1  depth==0.
- at_max  out  1  address=={ADDR_W{1}}.
- halted  out  1  state==HALTED.
- fault  out  1  state==FAULT.
- fault_code  out  2  00 none, 01 overflow (call on full), 10 underflow (ret on empty).

Behaviour:
- Clock and reset: one clock, clk. Reset is clear: synchronous, active-high, highest priority in every state.
- On clear: address=0, depth=0, state=RUN, fault_code=00. Stack contents need not be zeroed.
- Derived outputs: stack_full, stack_empty, at_max, halted and fault are combinational decodes of registered state. After clear: empty=1, full=0, at_max=0, halted=0, fault=0.
- Latency: every operation updates address on the next rising edge (1 cycle). No combinational path from inputs to address.
- FSM states: RUN, HALTED, FAULT.
- RUN → HALTED: halt=1 in RUN. The operation priority resolution below is skipped that cycle and address holds.
- HALTED → RUN: resume=1. All other inputs are ignored in HALTED; address and stack hold.
- RUN → FAULT: a stack error. FAULT holds address, stack and fault_code until clear; resume is ignored.
- RUN operation priority, one operation per cycle, lower ones ignored: ret > call > load > jump_rel > up > hold.
- ret, depth>0: address ← top entry; depth−1.
- ret, depth==0: no change to address; state ← FAULT; fault_code ← 10.
- call, depth<STACK_DEPTH: push (address+1 mod 2^ADDR_W); address ← load_addr; depth+1.
- call, full: no push, no jump; state ← FAULT; fault_code ← 01.
- load: address ← load_addr.
- jump_rel: address ← address + sign-extended offset, modulo 2^ADDR_W. Always wraps regardless of WRAP.
- up, WRAP=1: max+1 → 0.
- up, WRAP=0: address stays at max; at_max stays 1.
- Simultaneous halt with any operation in RUN: halt wins.
- Simultaneous halt and resume in HALTED: resume wins (RUN next cycle).
- clear together with anything: clear wins.

Decomposition:
- Package pc_seq_pkg holds:
  - typedef enum logic [1:0] state_t {RUN, HALTED, FAULT}.
  - typedef enum logic [1:0] fault_t {F_NONE, F_OVF, F_UNF}.
  - Localparam helpers for depth width.
- One natural sub-module: ras_stack, a LIFO of STACK_DEPTH × ADDR_W with push, pop, depth, full and empty, reset by clear.
- The top-level holds the FSM, priority mux and PC register.

Test Plan:
- clear, then up for 130 cycles, WRAP=1, ADDR_W=7: address counts 0..127, wraps to 0 at cycle 128, then reads 2 at cycle 130. at_max is high only when address=127.
- WRAP=0: load 126, then up ×3: address 127,127,127; at_max=1.
- address=10, jump_rel with offset=−3 (5'b11101): address=7. Then offset=+15: address=22. From 125 with offset +5: address=2.
- address=20, call load_addr=50: address=50, depth=1, stack top=21. Then ret: address=21, depth=0, stack_empty=1.
- STACK_DEPTH=4, four calls then a fifth: fault=1, fault_code=01, depth=4, address unchanged. Then resume: no change. Then clear: address=0, fault=0.
- ret on empty: fault_code=10. Separately, in RUN assert halt and up together at address=5: halted=1, address=5. up while halted: still 5. resume: RUN next cycle, then up gives 6.
